mem_io_responder: RTL and testbench
===================================

// Module: mem_io_responder
// PURPOSE
// Memory-side responder for the LC-3 datapath's MAR/MDR memory port. Services one
// read or write at a time over a 4-phase req/rdy handshake, with configurable wait
// states. Backs addresses with on-chip RAM; 0xFFFF is memory-mapped I/O
// (read = switches, write = hex display register). Read data drives the datapath's MDR_In.
// PARAMETERS
// ADDR_W       10   RAM index width; RAM holds 2**ADDR_W 16-bit words
// WAIT_CYCLES  2    wait states between request accept and Mem_Rdy (0..15)
// PORTS
// Clk        in   1   system clock, all state on rising edge
// Reset_n    in   1   asynchronous, active-low reset
// Mem_Req    in   1   request; held high by requester until Mem_Rdy seen
// Mem_WE     in   1   1 = write, 0 = read; sampled with Mem_Req at accept
// MAR        in   16  request address
// MDR        in   16  write data
// Switches   in   16  board switches, asynchronous to Clk
// MDR_In     out  16  read data to datapath MDR mux
// Mem_Rdy    out  1   one-cycle completion strobe
// Mem_Err    out  1   high with Mem_Rdy when address unmapped
// Hex_Out    out  16  hex display register
// BEHAVIOUR
// - Reset (Reset_n low, async): state IDLE, MDR_In=0, Mem_Rdy=0, Mem_Err=0,
//   Hex_Out=0, wait counter=0, switch synchroniser=0. RAM contents not reset.
// - Switches pass through a 2-flop synchroniser; reads of 0xFFFF return the
//   synchronised value as of the RESP-entry edge.
// - FSM: IDLE -> WAIT -> RESP -> DONE -> IDLE.
//   IDLE: Mem_Req=1 at edge k: latch MAR, MDR, Mem_WE; counter:=WAIT_CYCLES;
//     go WAIT (or straight to RESP if WAIT_CYCLES=0).
//   WAIT: decrement counter each edge; at counter==1 go RESP.
//   RESP: Mem_Rdy=1 (and Mem_Err if unmapped) for exactly this one cycle; go DONE.
//   DONE: stay until Mem_Req=0, then IDLE. No new request accepted before IDLE.
// - Latency: Mem_Rdy high in cycle k+1+WAIT_CYCLES after accept edge k.
// - Side effects commit on the edge entering RESP: RAM write, Hex_Out write,
//   MDR_In load for reads. MDR_In holds until the next read commits (writes
//   do not change it).
// - Address map: MAR==16'hFFFF -> I/O; MAR < 2**ADDR_W -> RAM[MAR[ADDR_W-1:0]];
//   else unmapped: read returns 16'h0000, write dropped, Mem_Err=1 with Mem_Rdy.
// - MAR/MDR/Mem_WE changes after accept are ignored (latched copies used).
// - Mem_Req dropped during WAIT: transaction still completes; Mem_Rdy still
//   pulses; DONE sees Req=0 and returns to IDLE next edge.
// - Reset mid-transaction: uncommitted write discarded; no Mem_Rdy issued.
// - Counter width 4 bits; WAIT_CYCLES>15 is a compile-time error.
// STRUCTURE
// - Package lc3_mem_pkg: state enum {IDLE,WAIT,RESP,DONE}, IO_SWITCH_ADDR=16'hFFFF,
//   IO_HEX_ADDR=16'hFFFF, word type logic [15:0].
// - Sub-module sp_ram (single-port sync RAM, params ADDR_W/DATA_W=16, 1-cycle read);
//   read issued on accept so data ready by RESP-entry; with WAIT_CYCLES=0 the read
//   address is driven combinationally from MAR during IDLE.
// - Top: FSM, wait counter, latches, synchroniser, address decode, Hex register.
// TESTING
// 1. Reset: Reset_n low mid-cycle -> all outputs 0 immediately, FSM IDLE.
// 2. Write 16'hBEEF to 0x0012, then read 0x0012 (WAIT_CYCLES=2) -> Mem_Rdy in cycle
//    k+3 each, MDR_In=16'hBEEF after read, Mem_Err=0.
// 3. I/O: Switches=16'h00A5, read 0xFFFF -> MDR_In=16'h00A5; write 16'h1234 to
//    0xFFFF -> Hex_Out=16'h1234, RAM untouched.
// 4. Unmapped: read 0x8000 (ADDR_W=10) -> MDR_In=0, Mem_Err=1 with Mem_Rdy;
//    write 0x8000 -> RAM unchanged.
// 5. Handshake: hold Mem_Req high 5 cycles past Mem_Rdy -> single Mem_Rdy pulse,
//    no second access; WAIT_CYCLES=0 build -> Mem_Rdy in cycle k+1.
// 6. Reset during WAIT of write 16'h5555 to 0x0003 -> no Mem_Rdy, RAM[3] keeps old value.

Source files
------------

// File: rtl/lc3_mem_pkg.sv
// Shared types and I/O address constants for the LC-3 memory-port responder.
package lc3_mem_pkg;

  typedef logic [15:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    DONE
  } state_e;

  localparam word_t IO_SWITCH_ADDR = 16'hFFFF;
  localparam word_t IO_HEX_ADDR    = 16'hFFFF;
  localparam int    CNT_W          = 4;
  localparam int    MAX_WAIT       = (1 << CNT_W) - 1;

endpackage

// File: rtl/sp_ram.sv
// Single-port synchronous RAM: one access per cycle, write or registered read.
module sp_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              Clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];

  // rdata only moves on a read, so it holds the last word fetched
  always_ff @(posedge Clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/mem_io_responder.sv
// Memory-side responder for the LC-3 MAR/MDR port: RAM plus switch/hex I/O at 0xFFFF,
// one transaction at a time over a 4-phase req/rdy handshake with fixed wait states.
module mem_io_responder
  import lc3_mem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Mem_Req,
  input  logic        Mem_WE,
  input  logic [15:0] MAR,
  input  logic [15:0] MDR,
  input  logic [15:0] Switches,
  output logic [15:0] MDR_In,
  output logic        Mem_Rdy,
  output logic        Mem_Err,
  output logic [15:0] Hex_Out
);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > MAX_WAIT) begin : g_bad_wait
    $error("WAIT_CYCLES must be in 0..15");
  end
  if (ADDR_W < 1 || ADDR_W > 16) begin : g_bad_addr
    $error("ADDR_W must be in 1..16");
  end

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  function automatic logic is_ram(input word_t a);
    return (a != IO_SWITCH_ADDR) && ((32'(a) >> ADDR_W) == 32'd0);
  endfunction

  state_e           state;
  logic [CNT_W-1:0] cnt;
  word_t            sw_s1;
  word_t            sw_s2;
  word_t            hex_q;
  logic             rdy_q;
  logic             err_q;

  logic             accept;
  logic             commit;
  word_t            cur_addr;
  word_t            cur_data;
  logic             cur_we;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  word_t             ram_q;

  assign accept = (state == IDLE) && Mem_Req;

  // With no wait states the request is serviced on the accept edge itself,
  // so the live bus is used; otherwise the copies latched at accept are.
  if (WAIT_CYCLES == 0) begin : g_direct
    assign commit   = accept;
    assign cur_addr = MAR;
    assign cur_data = MDR;
    assign cur_we   = Mem_WE;
  end else begin : g_latched
    word_t mar_q;
    word_t mdr_q;
    logic  we_q;

    always_ff @(posedge Clk) begin
      if (accept) begin
        mar_q <= MAR;
        mdr_q <= MDR;
        we_q  <= Mem_WE;
      end
    end

    assign commit   = (state == WAIT) && (cnt == CNT_W'(1));
    assign cur_addr = mar_q;
    assign cur_data = mdr_q;
    assign cur_we   = we_q;
  end

  // RAM reads are launched at accept so the word is ready by the commit edge
  always_comb begin
    ram_addr = accept ? MAR[ADDR_W-1:0] : cur_addr[ADDR_W-1:0];
    ram_en   = (accept && !Mem_WE && is_ram(MAR)) ||
               (commit && cur_we && is_ram(cur_addr));
    ram_we   = commit && cur_we;
  end

  sp_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (16)
  ) u_ram (
    .Clk   (Clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (cur_data),
    .rdata (ram_q)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= Switches;
      sw_s2 <= sw_s1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      rdy_q <= 1'b0;
      err_q <= 1'b0;
      hex_q <= '0;
    end else begin
      rdy_q <= commit;
      err_q <= commit && (cur_addr != IO_SWITCH_ADDR) && !is_ram(cur_addr);
      if (commit && cur_we && (cur_addr == IO_HEX_ADDR)) begin
        hex_q <= cur_data;
      end
      case (state)
        IDLE: begin
          if (Mem_Req) begin
            cnt   <= WAIT_INIT;
            state <= (WAIT_CYCLES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= RESP;
          end
        end
        RESP: state <= DONE;
        DONE: begin
          if (!Mem_Req) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Zero-wait reads commit on the same edge the RAM fetches, so the RAM output
  // is selected directly; it cannot change again until the next RAM read.
  if (WAIT_CYCLES == 0) begin : g_mdr_direct
    logic  rd_from_ram;
    word_t rd_hold;

    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        rd_from_ram <= 1'b0;
        rd_hold     <= '0;
      end else if (commit && !cur_we) begin
        rd_from_ram <= is_ram(cur_addr);
        rd_hold     <= (cur_addr == IO_SWITCH_ADDR) ? sw_s2 : '0;
      end
    end

    assign MDR_In = rd_from_ram ? ram_q : rd_hold;
  end else begin : g_mdr_reg
    word_t mdr_in_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        mdr_in_q <= '0;
      end else if (commit && !cur_we) begin
        if (cur_addr == IO_SWITCH_ADDR) begin
          mdr_in_q <= sw_s2;
        end else if (is_ram(cur_addr)) begin
          mdr_in_q <= ram_q;
        end else begin
          mdr_in_q <= '0;
        end
      end
    end

    assign MDR_In = mdr_in_q;
  end

  assign Mem_Rdy = rdy_q;
  assign Mem_Err = err_q;
  assign Hex_Out = hex_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Randomised bench for mem_io_responder against a word-level memory/I-O model.
module tb_mem_io_responder;

  localparam int W      = 2;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Mem_Req, Mem_Req0, Mem_WE;
  logic [15:0] MAR, MDR, Switches;
  logic [15:0] MDR_In, Hex_Out, MDR_In0, Hex_Out0;
  logic        Mem_Rdy, Mem_Err, Mem_Rdy0, Mem_Err0;

  int total = 0;
  int bad   = 0;

  logic [15:0] ram_m [0:DEPTH-1];
  bit          ram_v [0:DEPTH-1];
  logic [15:0] mdr_m, hex_m;
  bit          mdr_known;

  always #5 Clk = ~Clk;

  mem_io_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Mem_Req(Mem_Req), .Mem_WE(Mem_WE),
    .MAR(MAR), .MDR(MDR), .Switches(Switches), .MDR_In(MDR_In),
    .Mem_Rdy(Mem_Rdy), .Mem_Err(Mem_Err), .Hex_Out(Hex_Out)
  );

  mem_io_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(0)) dut0 (
    .Clk(Clk), .Reset_n(Reset_n), .Mem_Req(Mem_Req0), .Mem_WE(Mem_WE),
    .MAR(MAR), .MDR(MDR), .Switches(Switches), .MDR_In(MDR_In0),
    .Mem_Rdy(Mem_Rdy0), .Mem_Err(Mem_Err0), .Hex_Out(Hex_Out0)
  );

  function automatic bit in_ram(input logic [15:0] a);
    return (a != 16'hFFFF) && (int'(a) < DEPTH);
  endfunction

  task automatic set_switches(input logic [15:0] v);
    @(negedge Clk);
    Switches = v;
    repeat (3) @(negedge Clk);
  endtask

  // One full transaction on the main DUT, checked against the model.
  task automatic txn(input logic we, input logic [15:0] a, input logic [15:0] d,
                     input bit drop_early, input int hold);
    int n;
    int pulses;
    bit seen;
    bit exp_err;
    @(negedge Clk);
    Mem_WE = we; MAR = a; MDR = d; Mem_Req = 1'b1;
    @(posedge Clk); #1;
    MAR = 16'($urandom); MDR = 16'($urandom); Mem_WE = 1'($urandom);
    if (drop_early) Mem_Req = 1'b0;
    exp_err = (a != 16'hFFFF) && !in_ram(a);
    if (we) begin
      if (a == 16'hFFFF) hex_m = d;
      else if (in_ram(a)) begin
        ram_m[a[ADDR_W-1:0]] = d;
        ram_v[a[ADDR_W-1:0]] = 1'b1;
      end
    end else begin
      mdr_known = 1'b1;
      if (a == 16'hFFFF) mdr_m = Switches;
      else if (in_ram(a)) begin
        mdr_known = ram_v[a[ADDR_W-1:0]];
        mdr_m     = ram_m[a[ADDR_W-1:0]];
      end else mdr_m = 16'h0000;
    end
    n = 0; seen = 1'b0;
    while (n < 20) begin
      if (Mem_Rdy) begin seen = 1'b1; break; end
      @(posedge Clk); #1;
      n++;
    end
    total++;
    if (!seen || n != W) begin
      bad++;
      $display("FAIL latency addr=%h we=%0d: got %0d cycles (seen=%0d) want %0d", a, we, n, seen, W);
    end
    total++;
    if (Mem_Err !== exp_err) begin
      bad++;
      $display("FAIL mem_err addr=%h: got %b want %b", a, Mem_Err, exp_err);
    end
    if (mdr_known) begin
      total++;
      if (MDR_In !== mdr_m) begin
        bad++;
        $display("FAIL mdr_in addr=%h we=%0d: got %h want %h", a, we, MDR_In, mdr_m);
      end
    end
    total++;
    if (Hex_Out !== hex_m) begin
      bad++;
      $display("FAIL hex_out addr=%h: got %h want %h", a, Hex_Out, hex_m);
    end
    pulses = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge Clk); #1;
      if (Mem_Rdy) pulses++;
    end
    Mem_Req = 1'b0;
    repeat (3) begin
      @(posedge Clk); #1;
      if (Mem_Rdy) pulses++;
    end
    total++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL extra_rdy addr=%h hold=%0d: got %0d extra pulses want 0", a, hold, pulses);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    total++;
    if (MDR_In !== 16'h0 || Mem_Rdy !== 1'b0 || Mem_Err !== 1'b0 || Hex_Out !== 16'h0) begin
      bad++;
      $display("FAIL %s: got mdr=%h rdy=%b err=%b hex=%h want all 0", tag, MDR_In, Mem_Rdy, Mem_Err, Hex_Out);
    end
  endtask

  task automatic test_reset;
    check_zero_outputs("reset_initial");
    txn(1'b1, 16'hFFFF, 16'hCAFE, 1'b0, 0);
    txn(1'b1, 16'h0001, 16'h7777, 1'b0, 0);
    txn(1'b0, 16'h0001, 16'h0000, 1'b0, 0);
    @(posedge Clk); #3;
    Reset_n = 1'b0;
    #1;
    check_zero_outputs("reset_async");
    @(negedge Clk);
    Reset_n = 1'b1;
    mdr_m = 16'h0; hex_m = 16'h0;
  endtask

  task automatic test_ram_rw;
    txn(1'b1, 16'h0012, 16'hBEEF, 1'b0, 0);
    txn(1'b0, 16'h0012, 16'h0000, 1'b0, 0);
    txn(1'b1, 16'h03FF, 16'h1357, 1'b0, 1);
    txn(1'b0, 16'h03FF, 16'h0000, 1'b0, 0);
    txn(1'b1, 16'h0000, 16'h2468, 1'b0, 0);
    txn(1'b0, 16'h0012, 16'h0000, 1'b0, 0);
  endtask

  task automatic test_io;
    set_switches(16'h00A5);
    txn(1'b0, 16'hFFFF, 16'h0000, 1'b0, 0);
    txn(1'b1, 16'hFFFF, 16'h1234, 1'b0, 0);
    txn(1'b0, 16'h03FF, 16'h0000, 1'b0, 0);
    set_switches(16'h5A3C);
    txn(1'b0, 16'hFFFF, 16'h0000, 1'b0, 0);
  endtask

  task automatic test_unmapped;
    txn(1'b0, 16'h8000, 16'h0000, 1'b0, 0);
    txn(1'b1, 16'h8000, 16'hDEAD, 1'b0, 0);
    txn(1'b1, 16'h0400, 16'hDEAD, 1'b0, 0);
    txn(1'b0, 16'h0000, 16'h0000, 1'b0, 0);
    txn(1'b0, 16'hFFFE, 16'h0000, 1'b0, 0);
  endtask

  task automatic test_handshake;
    txn(1'b1, 16'h0005, 16'hA5A5, 1'b0, 5);
    txn(1'b0, 16'h0005, 16'h0000, 1'b0, 5);
    txn(1'b0, 16'h0012, 16'h0000, 1'b1, 0);
    txn(1'b1, 16'h0006, 16'h0F0F, 1'b1, 0);
    txn(1'b0, 16'h0006, 16'h0000, 1'b0, 0);
  endtask

  task automatic test_zero_wait;
    logic [15:0] d;
    d = 16'($urandom);
    @(negedge Clk);
    Mem_WE = 1'b1; MAR = 16'h0020; MDR = d; Mem_Req0 = 1'b1;
    @(posedge Clk); #1;
    total++;
    if (Mem_Rdy0 !== 1'b1 || Mem_Err0 !== 1'b0) begin
      bad++;
      $display("FAIL w0_write_rdy: got rdy=%b err=%b want 1/0", Mem_Rdy0, Mem_Err0);
    end
    Mem_Req0 = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Mem_WE = 1'b0; MAR = 16'h0020; Mem_Req0 = 1'b1;
    @(posedge Clk); #1;
    total++;
    if (Mem_Rdy0 !== 1'b1 || MDR_In0 !== d) begin
      bad++;
      $display("FAIL w0_read: got rdy=%b mdr=%h want 1/%h", Mem_Rdy0, MDR_In0, d);
    end
    Mem_Req0 = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Mem_WE = 1'b1; MAR = 16'h0021; MDR = ~d; Mem_Req0 = 1'b1;
    @(posedge Clk); #1;
    Mem_Req0 = 1'b0;
    @(posedge Clk); #1;
    total++;
    if (MDR_In0 !== d || Mem_Rdy0 !== 1'b0) begin
      bad++;
      $display("FAIL w0_hold: got mdr=%h rdy=%b want %h/0", MDR_In0, Mem_Rdy0, d);
    end
    @(posedge Clk);
    @(negedge Clk);
    Mem_WE = 1'b0; MAR = 16'h9000; Mem_Req0 = 1'b1;
    @(posedge Clk); #1;
    total++;
    if (Mem_Rdy0 !== 1'b1 || Mem_Err0 !== 1'b1 || MDR_In0 !== 16'h0) begin
      bad++;
      $display("FAIL w0_unmapped: got rdy=%b err=%b mdr=%h want 1/1/0000", Mem_Rdy0, Mem_Err0, MDR_In0);
    end
    Mem_Req0 = 1'b0;
    repeat (2) @(posedge Clk);
  endtask

  task automatic test_reset_in_wait;
    int pulses;
    txn(1'b1, 16'h0003, 16'h0C0C, 1'b0, 0);
    @(negedge Clk);
    Mem_WE = 1'b1; MAR = 16'h0003; MDR = 16'h5555; Mem_Req = 1'b1;
    @(posedge Clk); #2;
    Reset_n = 1'b0; Mem_Req = 1'b0;
    pulses = 0;
    repeat (4) begin
      @(posedge Clk); #1;
      if (Mem_Rdy) pulses++;
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    mdr_m = 16'h0; hex_m = 16'h0;
    total++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL reset_wait_rdy: got %0d pulses want 0", pulses);
    end
    txn(1'b0, 16'h0003, 16'h0000, 1'b0, 0);
  endtask

  task automatic test_random;
    logic [15:0] a;
    int r;
    for (int i = 0; i < 16; i++) txn(1'b1, 16'(i), 16'($urandom), 1'b0, 0);
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 5) a = 16'($urandom_range(0, 15));
      else if (r <= 7) a = 16'hFFFF;
      else if (r == 8) a = 16'(DEPTH + $urandom_range(0, 16'hFFFE - DEPTH));
      else a = 16'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 7) == 0) set_switches(16'($urandom));
      txn(1'($urandom), a, 16'($urandom), ($urandom_range(0, 5) == 0),
          int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    Reset_n = 1'b0; Mem_Req = 1'b0; Mem_Req0 = 1'b0; Mem_WE = 1'b0;
    MAR = '0; MDR = '0; Switches = '0;
    mdr_m = '0; hex_m = '0; mdr_known = 1'b1;
    for (int i = 0; i < DEPTH; i++) ram_v[i] = 1'b0;
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    test_reset;
    test_ram_rw;
    test_io;
    test_unmapped;
    test_handshake;
    test_zero_wait;
    test_reset_in_wait;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
